line_sensor_eval: RTL and testbench
===================================

Name: line_sensor_eval

Overview:
- Consumes the 12-bit conversion results produced by the SPI ADC reader. Receives one sample per conversion, tagged with its channel (left, centre and right IR line sensors).
- Block-averages each channel and applies hysteresis thresholds to get a 3-bit line pattern. Decodes that pattern into a drive direction for the motor controller.
- Tracks how long the line has been lost and forces STOP after a configurable number of empty frames.

Parameters:
- DATA_W, 12, ADC sample width.
- AVG_LOG2, 2, log2 of samples averaged per channel per frame (4 samples).
- TH_HI, 12'd2400, average at or above this sets a channel's line bit.
- TH_LO, 12'd1800, average below this clears a channel's line bit. Constraint: TH_LO < TH_HI.
- LOST_LIMIT, 8'd32, number of consecutive all-clear frames before lost_line asserts.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- sample_valid, in, 1, one-cycle strobe; sample_data/sample_ch are valid.
- sample_ch, in, 2, 0=left, 1=centre, 2=right, 3=illegal.
- sample_data, in, DATA_W, ADC result.
- line_bits, out, 3, {left,centre,right} hysteresis-filtered line pattern.
- dir, out, 2, 00=FWD, 01=LEFT, 10=RIGHT, 11=STOP.
- frame_valid, out, 1, one-cycle pulse when line_bits/dir update.
- lost_line, out, 1, line absent for LOST_LIMIT frames.
- err_ch, out, 1, sticky: a sample with sample_ch==3 was seen.

Behaviour:
Reset (asynchronous, any time including mid-frame):
- All accumulators, sample counters and pipeline registers are cleared.
- Outputs: line_bits=000, dir=11, frame_valid=0, lost_line=0, err_ch=0, lost counter=0.

Accumulate:
- Runs every cycle independent of evaluation, so a sample is never dropped or stalled.
- Per channel, on sample_valid: sum += sample_data (sum width DATA_W+AVG_LOG2, cannot overflow) and cnt += 1.
- On the 2^AVG_LOG2-th sample: avg_ch = (sum + sample_data) >> AVG_LOG2, truncating. Then set ready_ch, clear sum, set cnt=0.
- sample_ch==3: sample is discarded and err_ch is set (stays set until reset).

Frame:
- A frame completes in the cycle where the last of the three ready flags becomes set.
- All ready flags clear in that same cycle.
- A channel that finishes again before the others keeps its newest avg and its ready flag stays set.

Pipeline (state names):
- EVAL1, one cycle after frame completion: per channel, avg >= TH_HI sets the bit; avg < TH_LO clears the bit; otherwise the bit holds its previous value.
- EVAL2, next cycle: register the decode below, update the lost counter, and pulse frame_valid.
- Latency: frame_valid is high exactly 2 cycles after the sample_valid that completed the frame.
- A new frame cannot complete during EVAL1/EVAL2, because at least 3 samples are needed.

Decode of the new line_bits {L,C,R}:
- 010 -> FWD.
- 101 -> FWD.
- 100 -> LEFT.
- 110 -> LEFT.
- 001 -> RIGHT.
- 011 -> RIGHT.
- 111 -> STOP (junction/end marker).
- 000 -> dir holds its previous value (coast) and the lost counter increments, saturating at LOST_LIMIT.
  - When the counter equals LOST_LIMIT, lost_line=1 and dir=STOP.

Lost counter:
- Any non-000 frame clears the lost counter and lost_line in the same EVAL2 cycle.

Decomposition:
- Shared package: direction encodings (DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_STOP), channel indices (CH_LEFT, CH_CENTRE, CH_RIGHT), and DATA_W.
- One sub-module is natural: line_ch_avg, a per-channel accumulator/averager with a ready flag, instantiated three times. Thresholding, decode and the lost counter stay in the top level.

Test Plan:
- Reset during accumulation: 2 left samples, then rst pulse mid-cycle -> outputs immediately 000/11/0/0/0. After that, 4 left samples alone produce no frame_valid.
- Basic forward frame: 4 samples per channel, L=1000, C=3000, R=1000, interleaved L,C,R -> frame_valid 2 cycles after the 12th sample, line_bits=010, dir=00.
- Averaging and truncation: centre samples 2398, 2399, 2400, 2402 (avg 2399, truncated) -> C bit not set from 0. Centre samples 2400 x4 -> bit set.
- Hysteresis hold: after C=1 (avg 3000), a frame with C avg 2000 -> C stays 1. C avg 1799 -> C clears.
- Turn and junction: frames 110 -> dir=01; 011 -> dir=10; 111 -> dir=11.
- Lost line and error:
  - From dir=01, apply 31 frames of 000 -> dir stays 01, lost_line=0. The 32nd frame -> lost_line=1, dir=11. One 010 frame -> lost_line=0, dir=00.
  - A sample_ch=3 strobe -> err_ch=1, no accumulator changes.

Source files
------------

// File: rtl/line_sensor_eval_pkg.sv
// Shared encodings for the IR line-sensor evaluator.
// Direction codes, channel indices and sample width.
package line_sensor_eval_pkg;
  localparam int DATA_W = 12;

  localparam logic [1:0] DIR_FWD   = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_STOP  = 2'b11;

  localparam logic [1:0] CH_LEFT    = 2'd0;
  localparam logic [1:0] CH_CENTRE  = 2'd1;
  localparam logic [1:0] CH_RIGHT   = 2'd2;
  localparam logic [1:0] CH_ILLEGAL = 2'd3;
endpackage

// File: rtl/line_ch_avg.sv
// Per-channel block averager with a ready flag.
// done is combinational: high on the sample that closes a block.
module line_ch_avg #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] avg,
  output logic              ready,
  output logic              done
);
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] cnt;

  assign sum_next = sum + SUM_W'(data);
  assign done     = load && (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      cnt   <= '0;
      avg   <= '0;
      ready <= 1'b0;
    end else begin
      if (load) begin
        if (done) begin
          avg <= sum_next[SUM_W-1:AVG_LOG2];
          sum <= '0;
          cnt <= '0;
        end else begin
          sum <= sum_next;
          cnt <= cnt + 1'b1;
        end
      end
      // Frame clear wins: the closing channel is the one that set done.
      if (clr)
        ready <= 1'b0;
      else if (done)
        ready <= 1'b1;
    end
  end
endmodule

// File: rtl/line_sensor_eval.sv
// Averages three IR line sensors, applies hysteresis and decodes
// a drive direction, with a lost-line timeout forcing STOP.
module line_sensor_eval #(
  parameter int                DATA_W     = 12,
  parameter int                AVG_LOG2   = 2,
  parameter logic [DATA_W-1:0] TH_HI      = 12'd2400,
  parameter logic [DATA_W-1:0] TH_LO      = 12'd1800,
  parameter logic [7:0]        LOST_LIMIT = 8'd32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [1:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  output logic [2:0]        line_bits,
  output logic [1:0]        dir,
  output logic              frame_valid,
  output logic              lost_line,
  output logic              err_ch
);
  import line_sensor_eval_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL1 = 2'd1;
  localparam logic [1:0] S_EVAL2 = 2'd2;

  logic [2:0]        load;
  logic [2:0]        done;
  logic [2:0]        ready;
  logic [DATA_W-1:0] avg [3];
  logic              frame_done;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [2:0]        bits_next;
  logic [1:0]        dir_next;
  logic [7:0]        lost_cnt;
  logic [7:0]        cnt_next;
  logic              lost_next;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign load[i] = sample_valid && (sample_ch == 2'(i));
    line_ch_avg #(
      .DATA_W  (DATA_W),
      .AVG_LOG2(AVG_LOG2)
    ) u_avg (
      .clk  (clk),
      .rst  (rst),
      .load (load[i]),
      .clr  (frame_done),
      .data (sample_data),
      .avg  (avg[i]),
      .ready(ready[i]),
      .done (done[i])
    );
  end

  assign frame_done  = (&(ready | done)) && (|done);
  assign frame_valid = (state == S_EVAL2);

  always_comb begin
    state_next = S_IDLE;
    unique case (state)
      S_EVAL1: state_next = S_EVAL2;
      default: state_next = frame_done ? S_EVAL1 : S_IDLE;
    endcase
  end

  // Channel index i maps to line_bits[2-i] so the pattern reads {L,C,R}.
  always_comb begin
    bits_next = line_bits;
    for (int i = 0; i < 3; i++) begin
      if (avg[i] >= TH_HI)
        bits_next[2-i] = 1'b1;
      else if (avg[i] < TH_LO)
        bits_next[2-i] = 1'b0;
    end
  end

  always_comb begin
    dir_next  = dir;
    cnt_next  = '0;
    lost_next = 1'b0;
    unique case (bits_next)
      3'b010, 3'b101: dir_next = DIR_FWD;
      3'b100, 3'b110: dir_next = DIR_LEFT;
      3'b001, 3'b011: dir_next = DIR_RIGHT;
      3'b111:         dir_next = DIR_STOP;
      default: begin
        cnt_next = (lost_cnt == LOST_LIMIT) ? lost_cnt : lost_cnt + 1'b1;
        if (cnt_next == LOST_LIMIT) begin
          lost_next = 1'b1;
          dir_next  = DIR_STOP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      line_bits <= 3'b000;
      dir       <= DIR_STOP;
      lost_cnt  <= '0;
      lost_line <= 1'b0;
      err_ch    <= 1'b0;
    end else begin
      state <= state_next;
      if (sample_valid && sample_ch == CH_ILLEGAL)
        err_ch <= 1'b1;
      if (state == S_EVAL1) begin
        line_bits <= bits_next;
        dir       <= dir_next;
        lost_cnt  <= cnt_next;
        lost_line <= lost_next;
      end
    end
  end
endmodule

// File: tb/tb_line_sensor_eval.sv
// Directed-vector bench for line_sensor_eval.
// Expected values are hand-computed from the sensor averages.
module tb_line_sensor_eval;
  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [11:0] sample_data;
  logic [2:0]  line_bits;
  logic [1:0]  dir;
  logic        frame_valid;
  logic        lost_line;
  logic        err_ch;

  int vectors;
  int miscompares;

  line_sensor_eval dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .line_bits   (line_bits),
    .dir         (dir),
    .frame_valid (frame_valid),
    .lost_line   (lost_line),
    .err_ch      (err_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [11:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic frame4(input logic [11:0] l, input logic [11:0] c0,
                        input logic [11:0] c1, input logic [11:0] c2,
                        input logic [11:0] c3, input logic [11:0] r);
    logic [11:0] cv [4];
    cv = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      send(2'd0, l);
      send(2'd1, cv[i]);
      send(2'd2, r);
    end
  endtask

  task automatic frame(input logic [11:0] l, input logic [11:0] c,
                       input logic [11:0] r);
    frame4(l, c, c, c, c, r);
  endtask

  // Called at the negedge right after the closing sample was captured.
  task automatic expect_frame(input string tag, input int bits,
                              input int d, input int lost);
    chk({tag, "_fv_early"}, frame_valid, 0);
    @(negedge clk);
    chk({tag, "_fv"}, frame_valid, 1);
    chk({tag, "_bits"}, line_bits, bits);
    chk({tag, "_dir"}, dir, d);
    chk({tag, "_lost"}, lost_line, lost);
    @(negedge clk);
    chk({tag, "_fv_drop"}, frame_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_ch    = 2'd0;
    sample_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_bits", line_bits, 0);
    chk("rst_dir", dir, 3);
    chk("rst_fv", frame_valid, 0);
    chk("rst_lost", lost_line, 0);
    chk("rst_err", err_ch, 0);
    rst = 1'b0;

    send(2'd0, 12'd1000);
    send(2'd0, 12'd1000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bits", line_bits, 0);
    chk("mid_rst_dir", dir, 3);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_lost", lost_line, 0);
    chk("mid_rst_err", err_ch, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) send(2'd0, 12'd1000);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (frame_valid) seen++;
    end
    chk("left_only_no_frame", seen, 0);

    frame4(12'd1000, 12'd2398, 12'd2399, 12'd2400, 12'd2402, 12'd1000);
    expect_frame("trunc_2399", 3'b000, 3, 0);
    frame(12'd1000, 12'd2400, 12'd1000);
    expect_frame("c_2400_sets", 3'b010, 0, 0);
    frame(12'd1000, 12'd3000, 12'd1000);
    expect_frame("fwd_3000", 3'b010, 0, 0);
    frame(12'd1000, 12'd2000, 12'd1000);
    expect_frame("hyst_hold", 3'b010, 0, 0);
    frame(12'd1000, 12'd1799, 12'd1000);
    expect_frame("hyst_clear", 3'b000, 0, 0);
    frame(12'd3000, 12'd1000, 12'd3000);
    expect_frame("p101", 3'b101, 0, 0);
    frame(12'd3000, 12'd3000, 12'd1000);
    expect_frame("p110", 3'b110, 1, 0);
    frame(12'd1000, 12'd3000, 12'd3000);
    expect_frame("p011", 3'b011, 2, 0);
    frame(12'd3000, 12'd3000, 12'd3000);
    expect_frame("p111", 3'b111, 3, 0);
    frame(12'd3000, 12'd1000, 12'd1000);
    expect_frame("p100", 3'b100, 1, 0);
    frame(12'd1000, 12'd1000, 12'd3000);
    expect_frame("p001", 3'b001, 2, 0);
    frame(12'd3000, 12'd3000, 12'd1000);
    expect_frame("p110_again", 3'b110, 1, 0);

    for (int i = 0; i < 31; i++) begin
      frame(12'd1000, 12'd1000, 12'd1000);
      expect_frame($sformatf("empty_%0d", i + 1), 3'b000, 1, 0);
    end
    frame(12'd1000, 12'd1000, 12'd1000);
    expect_frame("empty_32", 3'b000, 3, 1);
    frame(12'd1000, 12'd3000, 12'd1000);
    expect_frame("recover", 3'b010, 0, 0);

    chk("err_before", err_ch, 0);
    send(2'd3, 12'd4000);
    chk("err_set", err_ch, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_ch, 1);
    frame(12'd3000, 12'd1000, 12'd1000);
    expect_frame("after_err", 3'b100, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
